uart_baud_gen: RTL and testbench
================================

# uart_baud_gen

Parametrised UART baud-rate generator replacing the fixed-ratio clock divider. A fractional phase accumulator (NCO) produces a single-cycle oversample strobe and a bit strobe from the 50 MHz system clock, with a runtime-reprogrammable rate. It also provides a legacy square-wave baud clock and an optional receiver resynchronisation input. It feeds the UART TX/RX shifters of the ADC data link.

## Interface
- CLK_HZ, 50000000, system clock frequency in Hz
- BAUD, 9600, reset baud rate
- OSR, 16, oversample ratio; power of two, ≥4
- ACC_W, 24, accumulator width; increment resolution 2^-ACC_W
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high; clock clk
- en  in  1  run enable; 0 freezes all state
- cfg_valid  in  1  new increment offered
- cfg_inc  in  ACC_W  increment, equal to round(baud·OSR·2^ACC_W / CLK_HZ)
- cfg_ready  out  1  increment can be accepted
- sync  in  1  resync pulse (only with BAUD_GEN_SYNC_EN)
- os_tick  out  1  oversample strobe, one cycle
- bit_tick  out  1  bit-period strobe, one cycle
- os_cnt  out  clog2(OSR)  oversample phase within the bit
- baud_clk  out  1  square wave at the baud rate, high for the second half of each bit

## Operation
- DEF_INC = round(BAUD·OSR·2^ACC_W / CLK_HZ), computed with 64-bit constant arithmetic. With the defaults, DEF_INC = 51540.
- Reset values: acc=0, inc=DEF_INC, os_cnt=0, os_tick=0, bit_tick=0, baud_clk=0, cfg_ready=1, pending=0.
- en=1: on each edge, {carry,acc} <= acc + inc (ACC_W+1 bits, modulo wrap). os_tick <= carry.
- os_cnt advances on each os_tick and wraps OSR-1→0. On that wrap, bit_tick pulses in the same cycle as the os_tick.
- baud_clk is registered and equals os_cnt[MSB].
- en=0: acc, os_cnt, inc and pending hold. os_tick and bit_tick are forced to 0.
- Config handshake: a transfer occurs when cfg_valid & cfg_ready. cfg_inc is latched into pend_inc, pending is set, and cfg_ready drops.
- The pending value moves into inc on the edge that produces bit_tick, or on the next edge if en=0. pending then clears and cfg_ready rises.
- cfg_valid while cfg_ready=0 is ignored. No queueing.
- inc=0 is legal and stalls ticks. A pending update is then applied only while en=0.
- inc=2^ACC_W-1 produces os_tick on all but one cycle per 2^ACC_W. No carry is lost.

## Timing
- os_tick asserts for exactly one cycle, one cycle after the accumulating edge that carries.
- With default settings, the first os_tick appears on the 326th enabled cycle after reset release.
- bit_tick average period = CLK_HZ/BAUD cycles (5208.33 at defaults). Jitter is ≤1 clock per os_tick.
- The new inc takes effect on the first accumulation after the bit boundary. The bit in progress always completes at the old rate.
- rst mid-operation: all state returns to reset values on the same edge, and any pending update is discarded.

## Configuration
- BAUD_GEN_SYNC_EN defined: sync port present. A sync pulse (with en=1) sets acc=2^(ACC_W-1) and os_cnt=0, and suppresses any os_tick/bit_tick that edge. The next bit_tick therefore falls OSR os_ticks later, with the first os_tick half an oversample period away.
- Sync has priority over a normal update. Sync and cfg apply on the same edge: the config is applied, since the sync edge counts as a bit boundary.
- BAUD_GEN_SYNC_EN undefined: no sync port and no resync logic. Phase is free-running.

## Structure
- Shared package uart_pkg: calc_inc(clk_hz, baud, osr, acc_w) constant function, and DEF_CLK_HZ / DEF_BAUD / DEF_OSR constants.
- One sub-module, baud_nco: accumulator, inc register, carry → os_tick. The top level holds os_cnt, bit_tick, baud_clk, the config handshake and sync.

## Test plan
- Reset then en=1 with defaults → first os_tick at enabled cycle 326, and 1000±1 bit_ticks over 5,208,333 cycles.
- cfg_inc=618475 (115200 baud) issued mid-bit → cfg_ready low until the next bit_tick. The current bit finishes at ~5208 cycles, subsequent bits at ~434 cycles, and cfg_ready returns to 1.
- en=0 for 1000 cycles mid-bit → no ticks, with acc/os_cnt/baud_clk unchanged. Ticks resume with the same phase when en=1.
- BAUD_GEN_SYNC_EN, sync pulse at os_cnt=9 → os_cnt=0, first os_tick 163 cycles later, and bit_tick after 16 os_ticks.
- rst asserted with an update pending → all outputs return to reset values, cfg_ready=1, and rate reverts to DEF_INC.
- cfg_inc=2^24-1 → os_tick on nearly every cycle, bit_tick every 16 cycles (occasionally 17), and no missed carries over 10^6 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and the constant function that converts a baud rate
// into an NCO phase increment.
package uart_pkg;

  localparam int unsigned DEF_CLK_HZ = 50_000_000;
  localparam int unsigned DEF_BAUD   = 9600;
  localparam int unsigned DEF_OSR    = 16;

  // round(baud * osr * 2^acc_w / clk_hz), done in 64 bits so the shift cannot overflow
  function automatic longint unsigned calc_inc(input longint unsigned clk_hz,
                                               input longint unsigned baud,
                                               input longint unsigned osr,
                                               input int unsigned     acc_w);
    longint unsigned num;
    num = (baud * osr) << acc_w;
    return (num + (clk_hz / 2)) / clk_hz;
  endfunction

endpackage

// File: rtl/baud_nco.sv
// Fractional phase accumulator: adds inc every enabled cycle and turns the
// carry out of the top bit into a registered one-cycle os_tick.
module baud_nco #(
  parameter int unsigned       ACC_W   = 24,
  parameter logic [ACC_W-1:0]  DEF_INC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             load_i,
  input  logic [ACC_W-1:0] load_inc_i,
  output logic             carry_o,
  output logic             os_tick_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic             os_tick_q, os_tick_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, inc_q};
    carry_o   = en_i & ~sync_i & sum[ACC_W];
    os_tick_d = carry_o;
    acc_d     = acc_q;
    inc_d     = inc_q;
    // A resync parks the phase half an oversample period away from the next carry
    if (en_i) acc_d = sync_i ? {1'b1, {(ACC_W-1){1'b0}}} : sum[ACC_W-1:0];
    if (load_i) inc_d = load_inc_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      inc_q     <= DEF_INC;
      os_tick_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      inc_q     <= inc_d;
      os_tick_q <= os_tick_d;
    end
  end

  assign os_tick_o = os_tick_q;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: NCO oversample strobe, bit strobe, square baud clock and
// a one-deep rate-update handshake. Define BAUD_GEN_SYNC_EN for the sync input.
module uart_baud_gen import uart_pkg::*; #(
  parameter int unsigned CLK_HZ = DEF_CLK_HZ,
  parameter int unsigned BAUD   = DEF_BAUD,
  parameter int unsigned OSR    = DEF_OSR,
  parameter int unsigned ACC_W  = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cfg_valid,
  input  logic [ACC_W-1:0]        cfg_inc,
  output logic                    cfg_ready,
`ifdef BAUD_GEN_SYNC_EN
  input  logic                    sync,
`endif
  output logic                    os_tick,
  output logic                    bit_tick,
  output logic [$clog2(OSR)-1:0]  os_cnt,
  output logic                    baud_clk
);

  localparam int unsigned      CNT_W   = $clog2(OSR);
  localparam logic [ACC_W-1:0] DEF_INC = ACC_W'(calc_inc(64'(CLK_HZ), 64'(BAUD), 64'(OSR), ACC_W));

  logic             sync_w;
  logic             carry;
  logic             boundary;
  logic             load;
  logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
  logic             bit_tick_q, bit_tick_d;
  logic             baud_clk_q, baud_clk_d;
  logic             pending_q, pending_d;
  logic [ACC_W-1:0] pend_inc_q, pend_inc_d;

`ifdef BAUD_GEN_SYNC_EN
  assign sync_w = en & sync;
`else
  assign sync_w = 1'b0;
`endif

  baud_nco #(
    .ACC_W   (ACC_W),
    .DEF_INC (DEF_INC)
  ) u_nco (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .sync_i     (sync_w),
    .load_i     (load),
    .load_inc_i (pend_inc_q),
    .carry_o    (carry),
    .os_tick_o  (os_tick)
  );

  always_comb begin
    os_cnt_d   = os_cnt_q;
    bit_tick_d = 1'b0;
    boundary   = sync_w;
    if (sync_w) begin
      os_cnt_d = '0;
    end else if (carry) begin
      os_cnt_d = os_cnt_q + 1'b1;
      if (os_cnt_q == CNT_W'(OSR - 1)) begin
        bit_tick_d = 1'b1;
        boundary   = 1'b1;
      end
    end
    baud_clk_d = os_cnt_d[CNT_W-1];

    // Rate changes land only between bits, or immediately while stopped
    load       = pending_q & (~en | boundary);
    pending_d  = pending_q;
    pend_inc_d = pend_inc_q;
    if (load) begin
      pending_d = 1'b0;
    end else if (cfg_valid & ~pending_q) begin
      pending_d  = 1'b1;
      pend_inc_d = cfg_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      os_cnt_q   <= '0;
      bit_tick_q <= 1'b0;
      baud_clk_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      os_cnt_q   <= os_cnt_d;
      bit_tick_q <= bit_tick_d;
      baud_clk_q <= baud_clk_d;
      pending_q  <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_inc_q <= pend_inc_d;
  end

  assign cfg_ready = ~pending_q;
  assign bit_tick  = bit_tick_q;
  assign os_cnt    = os_cnt_q;
  assign baud_clk  = baud_clk_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: a phase-arithmetic model predicts every
// cycle's outputs; a negedge monitor compares them. Sync test needs BAUD_GEN_SYNC_EN.
module tb_uart_baud_gen;

  localparam int     OSR     = 16;
  localparam longint MODV    = 64'd1 << 24;
  localparam longint DEF_INC = 51540;

  logic        clk = 1'b0;
  logic        rst, en, cfg_valid, sync;
  logic [23:0] cfg_inc;
  logic        cfg_ready, os_tick, bit_tick, baud_clk;
  logic [3:0]  os_cnt;

  always #5 clk = ~clk;

  uart_baud_gen dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_inc   (cfg_inc),
    .cfg_ready (cfg_ready),
`ifdef BAUD_GEN_SYNC_EN
    .sync      (sync),
`endif
    .os_tick   (os_tick),
    .bit_tick  (bit_tick),
    .os_cnt    (os_cnt),
    .baud_clk  (baud_clk)
  );

  typedef struct packed {
    logic       os;
    logic       bt;
    logic [3:0] cnt;
    logic       bc;
    logic       rdy;
  } exp_t;

  exp_t   sb_q[$];
  int     n_vec = 0;
  int     n_err = 0;

  longint m_phase, m_inc, m_pinc;
  int     m_osn;
  bit     m_pend;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Model the edge about to happen from the current inputs, queue the result, clock once.
  task automatic step();
    exp_t e;
    bit   os, bt, bnd, rdy0;
    os = 0; bt = 0; bnd = 0;
    if (rst) begin
      m_phase = 0; m_inc = DEF_INC; m_osn = 0; m_pend = 0;
    end else begin
      rdy0 = !m_pend;
      if (en) begin
        if (sync) begin
          m_phase = MODV / 2; m_osn = 0; bnd = 1;
        end else begin
          m_phase += m_inc;
          if (m_phase >= MODV) begin
            m_phase -= MODV;
            os = 1;
            m_osn = (m_osn + 1) % OSR;
            if (m_osn == 0) begin bt = 1; bnd = 1; end
          end
        end
      end
      if (m_pend && (!en || bnd)) begin
        m_inc = m_pinc; m_pend = 0;
      end else if (cfg_valid && rdy0) begin
        m_pinc = longint'(cfg_inc); m_pend = 1;
      end
    end
    e.os = os; e.bt = bt; e.cnt = 4'(m_osn); e.bc = (m_osn >= OSR / 2); e.rdy = !m_pend;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e, g;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = {os_tick, bit_tick, os_cnt, baud_clk, cfg_ready};
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL outputs vec %0d: got os=%b bit=%b cnt=%0d bclk=%b rdy=%b, expected os=%b bit=%b cnt=%0d bclk=%b rdy=%b",
                 n_vec, g.os, g.bt, g.cnt, g.bc, g.rdy, e.os, e.bt, e.cnt, e.bc, e.rdy);
      end
    end
  end

  task automatic run_until_os(input int bound, output int k);
    k = 0;
    do begin step(); k++; end while (!os_tick && k < bound);
  endtask

  task automatic run_until_bit(input int bound, output int k);
    k = 0;
    do begin step(); k++; end while (!bit_tick && k < bound);
  endtask

  initial begin
    int k, ticks, cnt0, bc0, last_bt, nos;
    rst = 1; en = 0; cfg_valid = 0; cfg_inc = '0; sync = 0;
    repeat (3) step();
    check("reset_cfg_ready", cfg_ready, 1);
    check("reset_os_cnt", os_cnt, 0);
    check("reset_baud_clk", baud_clk, 0);

    // Default rate from reset
    rst = 0; en = 1;
    run_until_os(400, k);
    check("first_os_tick_cycle", k, 326);
    run_until_bit(6000, k);
    check("first_bit_tick_cycle", k + 326, 5209);

    // Rate change issued mid-bit: old bit completes, then 115200 baud
    repeat (1000) step();
    cfg_valid = 1; cfg_inc = 24'd618475;
    step();
    cfg_valid = 0;
    check("cfg_ready_low_after_xfer", cfg_ready, 0);
    run_until_bit(6000, k);
    check("old_rate_bit_period", k + 1001, 5208);
    check("cfg_ready_after_apply", cfg_ready, 1);
    run_until_bit(600, k);
    check("new_rate_bit_period_ok", (k >= 433 && k <= 435), 1);

    // Freeze mid-bit
    repeat (200) step();
    cnt0 = os_cnt; bc0 = baud_clk; ticks = 0;
    en = 0;
    repeat (1000) begin step(); ticks += os_tick + bit_tick; end
    check("frozen_ticks", ticks, 0);
    check("frozen_os_cnt", os_cnt, cnt0);
    check("frozen_baud_clk", baud_clk, bc0);
    en = 1;
    repeat (300) step();

    // Randomised enables, rate updates and occasional resets
    for (int i = 0; i < 4000; i++) begin
      int sel;
      en        = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 19) == 0);
      sel       = $urandom_range(0, 9);
      cfg_inc   = (sel == 0) ? 24'd0 : (sel == 1) ? 24'hFFFFFF : 24'($urandom_range(300000, 3000000));
      rst       = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 0; cfg_valid = 0;

    // Reset with an update pending discards it and restores the default rate
    en = 0;
    repeat (2) step();
    en = 1; cfg_valid = 1; cfg_inc = 24'd1000000;
    step();
    cfg_valid = 0;
    check("pending_before_rst", cfg_ready, 0);
    rst = 1;
    step();
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_os_tick", os_tick, 0);
    check("rst_bit_tick", bit_tick, 0);
    check("rst_os_cnt", os_cnt, 0);
    rst = 0;
    run_until_os(400, k);
    check("reverted_first_os_tick", k, 326);

`ifdef BAUD_GEN_SYNC_EN
    k = 0;
    while (os_cnt != 4'd9 && k < 6000) begin step(); k++; end
    check("reach_os_cnt_9", os_cnt, 9);
    sync = 1;
    step();
    sync = 0;
    check("sync_os_cnt", os_cnt, 0);
    run_until_os(400, k);
    check("sync_first_os_tick", k, 163);
    repeat (20) step();
`endif

    // Maximum increment: os_tick nearly every cycle, bits every 16 or 17 cycles
    en = 0; cfg_valid = 1; cfg_inc = 24'hFFFFFF;
    step();
    cfg_valid = 0;
    step();
    en = 1; nos = 0; last_bt = -1;
    for (int c = 0; c < 2000; c++) begin
      step();
      nos += os_tick;
      if (bit_tick) begin
        if (last_bt >= 0) check("max_inc_bit_interval", ((c - last_bt) == 16 || (c - last_bt) == 17), 1);
        last_bt = c;
      end
    end
    check("max_inc_os_ticks", (nos >= 1999), 1);

    en = 0;
    repeat (3) step();
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
